// File: rtl/shift_div_core_pkg.sv
// Shared state encoding and default sizing for the shift-based restoring divider.
package shift_div_core_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_div_core_shl1_pair.sv
// Combinational left shift by one of the {rem, quo} pair, zero into the LSB; zero latency.
// Passes the pair through unchanged when en is low; no flow control.
module shl1_pair
    import shift_div_core_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 en,
    input  logic [2*WIDTH-1:0]   din,
    output logic [2*WIDTH-1:0]   dout
);

    assign dout = en ? {din[2*WIDTH-2:0], 1'b0} : din;

endmodule

// File: rtl/shift_div_core.sv
// Unsigned restoring divider; done pulses WIDTH+1 cycles after start is accepted (1 for divide by zero).
// start is only sampled in IDLE and is ignored while busy; results hold until the next accepted start.
module shift_div_core
    import shift_div_core_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [2*WIDTH-1:0] pair_shifted;
    logic [WIDTH-1:0]   rem_sh;
    logic [WIDTH-1:0]   quo_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;

    shl1_pair #(.WIDTH(WIDTH)) u_shl1 (
        .en   (state == RUN),
        .din  ({rem_r, quo_r}),
        .dout (pair_shifted)
    );

    assign rem_sh = pair_shifted[2*WIDTH-1:WIDTH];
    assign quo_sh = pair_shifted[WIDTH-1:0];

    // The bit shifted out of rem is kept as the trial MSB so divisors above
    // 2^(WIDTH-1) cannot lose it; when it is set the subtraction never borrows.
    assign trial   = {rem_r[WIDTH-1], rem_sh} - {1'b0, dvs_r};
    assign rem_nxt = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
    assign quo_nxt = quo_sh | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_r == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            cnt_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo_r <= dividend;
                        rem_r <= '0;
                        dvs_r <= divisor;
                        cnt_r <= '0;
                        if (divisor == '0) begin
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == LAST_ITER) begin
                        quotient  <= quo_nxt;
                        remainder <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_div_core.sv
// Randomized and directed bench for shift_div_core against an arithmetic reference (a/b, a%b).
module tb_shift_div_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks = 0;
    int errors = 0;

    shift_div_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One division; optionally re-pulses start with other operands at cycle poke_cyc.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_cyc, input logic [W-1:0] pa, input logic [W-1:0] pb);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           lat;
        int           bcnt;
        int           exp_lat;
        bit           seen;
        eq      = (b == '0) ? '1 : a / b;
        er      = (b == '0) ? a : a % b;
        exp_lat = (b == '0) ? 1 : W + 1;

        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat  = 1;
        bcnt = busy ? 1 : 0;
        seen = done;
        while (!seen && lat < 100) begin
            if (lat == poke_cyc) begin
                dividend = pa;
                divisor  = pb;
                start    = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
            seen = done;
        end
        check("latency", lat, exp_lat);
        check("busy_cycles", bcnt, exp_lat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, (b == '0) ? 1 : 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("quotient_held", quotient, eq);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        rst_n = 1'b1;

        run_op(16'd100, 16'd7, 0, '0, '0);
        run_op(16'hFFFF, 16'd1, 0, '0, '0);
        run_op(16'hFFFF, 16'hFFFF, 0, '0, '0);
        run_op(16'd3, 16'd10, 0, '0, '0);
        run_op(16'd0, 16'd5, 0, '0, '0);
        run_op(16'd5, 16'd0, 0, '0, '0);
        run_op(16'd9, 16'd3, 0, '0, '0);
        run_op(16'd1000, 16'd3, 5, 16'd8, 16'd2);
        run_op(16'hFFFF, 16'h8001, 0, '0, '0);

        // Reset mid-operation: everything clears at once and no done follows.
        @(negedge clk);
        dividend = 16'd50000;
        divisor  = 16'd123;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_abort_no_done", done, 0);
        end
        run_op(16'd50000, 16'd123, 0, '0, '0);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = W'($urandom_range(0, 15));
                1:       rb = W'($urandom_range(16'h8000, 16'hFFFF));
                default: rb = W'($urandom);
            endcase
            run_op(ra, rb, (i % 4 == 0) ? 3 : 0, W'($urandom), W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
